// File: rtl/sklansky_pipe_adder_if.sv
// Operand/result handshake bundle for sklansky_pipe_adder.
// master drives operands and out_ready; slave is the adder.
interface sklansky_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/sklansky_pipe_adder.sv
// Fully pipelined Sklansky prefix adder/subtractor: pre-process, one stage per prefix level, post-process.
// Build option: define SKLANSKY_OVF_EN to produce the two's-complement overflow flag.
module sklansky_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sklansky_pipe_adder_if.slave bus
);
  localparam int LEVELS = $clog2(WIDTH);

  logic             stall_s;
  logic             adv_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] g0_s;
  logic [WIDTH-1:0] p0_s;
  logic             c0_s;

  logic [LEVELS:0]  vld_r;
  logic [LEVELS:0]  c0_r;
  logic [WIDTH-1:0] grp_g_r [0:LEVELS];
  logic [WIDTH-1:0] grp_p_r [0:LEVELS];
  logic [WIDTH-1:0] bit_p_r [0:LEVELS];
  logic [WIDTH-1:0] grp_g_s [1:LEVELS];
  logic [WIDTH-1:0] grp_p_s [1:LEVELS];

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             out_valid_r;

  // Last bit of the aligned group that bit i joins at prefix level k.
  function automatic int grp_tail(input int i, input int k);
    return ((i >> (k - 32'sd1)) << (k - 32'sd1)) - 32'sd1;
  endfunction

  assign stall_s      = out_valid_r & ~bus.out_ready;
  assign adv_s        = ~stall_s;
  assign bus.in_ready = adv_s;

  // Operand conditioning; carry-in is folded into bit 0 generate so G[i] means G[i:-1].
  always_comb begin
    b_s     = bus.in_sub ? ~bus.in_b : bus.in_b;
    c0_s    = bus.in_sub ? 1'b1 : bus.in_cin;
    p0_s    = bus.in_a ^ b_s;
    g0_s    = bus.in_a & b_s;
    g0_s[0] = g0_s[0] | (p0_s[0] & c0_s);
  end

  // Sklansky combine network for every level, each fed from the previous level's registers.
  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      grp_g_s[k] = grp_g_r[k-1];
      grp_p_s[k] = grp_p_r[k-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (i[k-1]) begin
          grp_g_s[k][i] = grp_g_r[k-1][i] | (grp_p_r[k-1][i] & grp_g_r[k-1][grp_tail(i, k)]);
          grp_p_s[k][i] = grp_p_r[k-1][i] & grp_p_r[k-1][grp_tail(i, k)];
        end else begin
          grp_g_s[k][i] = grp_g_r[k-1][i];
          grp_p_s[k][i] = grp_p_r[k-1][i];
        end
      end
    end
  end

  // Post-process: bit i sums with the group carry out of bits [i-1:-1].
  always_comb begin
    sum_s  = bit_p_r[LEVELS] ^ {grp_g_r[LEVELS][WIDTH-2:0], c0_r[LEVELS]};
    cout_s = grp_g_r[LEVELS][WIDTH-1];
  end

  // Valid bits shift only when the pipe advances; bubbles travel with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (adv_s) begin
      vld_r       <= {vld_r[LEVELS-1:0], bus.in_valid};
      out_valid_r <= vld_r[LEVELS];
    end
  end

  // Stage data registers load only when a valid beat moves into them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_r <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        grp_g_r[k] <= '0;
        grp_p_r[k] <= '0;
        bit_p_r[k] <= '0;
      end
    end else if (adv_s) begin
      if (bus.in_valid) begin
        grp_g_r[0] <= g0_s;
        grp_p_r[0] <= p0_s;
        bit_p_r[0] <= p0_s;
        c0_r[0]    <= c0_s;
      end
      for (int k = 1; k <= LEVELS; k++) begin
        if (vld_r[k-1]) begin
          grp_g_r[k] <= grp_g_s[k];
          grp_p_r[k] <= grp_p_s[k];
          bit_p_r[k] <= bit_p_r[k-1];
          c0_r[k]    <= c0_r[k-1];
        end
      end
    end
  end

  // Result registers hold while stalled so the output stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (adv_s && vld_r[LEVELS]) begin
      sum_r  <= sum_s;
      cout_r <= cout_s;
    end
  end

`ifdef SKLANSKY_OVF_EN
  logic ovf_r;

  // Overflow is the carry into the MSB disagreeing with the carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (adv_s && vld_r[LEVELS]) begin
      ovf_r <= grp_g_r[LEVELS][WIDTH-2] ^ cout_s;
    end
  end

  assign bus.out_ovf = ovf_r;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = sum_r;
  assign bus.out_cout  = cout_r;
endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Self-checking bench for sklansky_pipe_adder: WIDTH=4 vector table plus WIDTH=16 stream,
// backpressure and mid-stream reset against an arithmetic reference model.
module tb_sklansky_pipe_adder;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

`ifdef SKLANSKY_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  sklansky_pipe_adder_if #(.WIDTH(4))  if4 ();
  sklansky_pipe_adder_if #(.WIDTH(16)) if16 ();

  sklansky_pipe_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  sklansky_pipe_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec4_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp16_t;

  vec4_t       tbl [8];
  exp16_t      exp_q [$];
  exp16_t      sb_e;
  bit          sb_en = 1'b0;
  int          accepts, pops, first_acc, first_pop, last_pop;
  logic [63:0] m_sum;
  logic        m_cout, m_ovf;
  logic [3:0]  r_sum4;
  logic [15:0] r_sum16, held;
  logic        r_cout, r_ovf;
  int          lat, guard;
  logic [3:0]  ra, rb;
  logic        rcin, rsub;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] sum, output logic cout, output logic ovf);
    longint span, half, ua, ub, sa, sb, full, sres;
    span = 64'sd1 << w;
    half = span / 64'sd2;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua >= half) ? ua - span : ua;
    sb   = (ub >= half) ? ub - span : ub;
    if (sub) begin
      full = ua - ub;
      cout = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      cout = (full >= span);
      sres = sa + sb + longint'(cin);
    end
    sum = full & (span - 64'sd1);
    ovf = OVF_ON & ((sres >= half) | (sres < -half));
  endfunction

  // Scoreboard for the 16-bit instance: predict on accept, compare on consume.
  always @(negedge clk) begin
    if (sb_en) begin
      if (if16.out_valid && if16.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: result %0h with nothing outstanding", if16.out_sum);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_sum", 64'(if16.out_sum), 64'(sb_e.sum));
          chk("sb_cout", 64'(if16.out_cout), 64'(sb_e.cout));
          chk("sb_ovf", 64'(if16.out_ovf), 64'(sb_e.ovf));
          pops++;
          if (pops == 1) first_pop = cyc;
          last_pop = cyc;
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        model(16, 64'(if16.in_a), 64'(if16.in_b), if16.in_cin, if16.in_sub, m_sum, m_cout, m_ovf);
        sb_e.sum  = m_sum[15:0];
        sb_e.cout = m_cout;
        sb_e.ovf  = m_ovf;
        exp_q.push_back(sb_e);
        accepts++;
        if (accepts == 1) first_acc = cyc + 1;
      end
    end
  end

  task automatic beat4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub,
                       output logic [3:0] sum, output logic cout, output logic ovf, output int l);
    if4.in_a = a; if4.in_b = b; if4.in_cin = cin; if4.in_sub = sub; if4.in_valid = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    l = 1;
    while (!if4.out_valid && l < 40) begin @(posedge clk); #1; l++; end
    sum = if4.out_sum; cout = if4.out_cout; ovf = if4.out_ovf;
  endtask

  task automatic beat16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        output logic [15:0] sum, output logic cout, output logic ovf, output int l);
    if16.in_a = a; if16.in_b = b; if16.in_cin = cin; if16.in_sub = sub; if16.in_valid = 1'b1;
    @(negedge clk);
    chk("w16_in_ready", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    l = 1;
    while (!if16.out_valid && l < 40) begin @(posedge clk); #1; l++; end
    sum = if16.out_sum; cout = if16.out_cout; ovf = if16.out_ovf;
  endtask

  task automatic send16(input int n, input bit mix_sub);
    int  g;
    bit  acc;
    for (int j = 0; j < n; j++) begin
      if16.in_a   = 16'($urandom);
      if16.in_b   = 16'($urandom);
      if16.in_cin = 1'($urandom);
      if16.in_sub = mix_sub & ($urandom_range(32'd0, 32'd3) == 32'd0);
      if16.in_valid = 1'b1;
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 200) begin
        @(negedge clk);
        acc = if16.in_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL send16_timeout: beat %0d never accepted", j);
      end
    end
    if16.in_valid = 1'b0;
  endtask

  task automatic drain16();
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin @(posedge clk); #1; guard++; end
  endtask

  initial begin
    tbl[0] = '{4'b1101, 4'b1011, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0};
    tbl[2] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[3] = '{4'b0101, 4'b0111, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0};
    tbl[4] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
    tbl[5] = '{4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1};
    tbl[6] = '{4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[7] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1};

    rst = 1'b1;
    if4.in_valid = 1'b0;  if4.in_a = '0;  if4.in_b = '0;  if4.in_cin = 1'b0;  if4.in_sub = 1'b0;  if4.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0; if16.in_sub = 1'b0; if16.out_ready = 1'b1;
    #12;
    chk("rst4_valid", 64'(if4.out_valid), 64'd0);
    chk("rst4_sum", 64'(if4.out_sum), 64'd0);
    chk("rst4_cout", 64'(if4.out_cout), 64'd0);
    chk("rst4_ovf", 64'(if4.out_ovf), 64'd0);
    chk("rst4_in_ready", 64'(if4.in_ready), 64'd1);
    chk("rst16_valid", 64'(if16.out_valid), 64'd0);
    chk("rst16_sum", 64'(if16.out_sum), 64'd0);
    chk("rst16_in_ready", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      beat4(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, r_sum4, r_cout, r_ovf, lat);
      chk("tbl_sum", 64'(r_sum4), 64'(tbl[i].sum));
      chk("tbl_cout", 64'(r_cout), 64'(tbl[i].cout));
      chk("tbl_ovf", 64'(r_ovf), 64'(tbl[i].ovf & OVF_ON));
      chk("tbl_latency", 64'(lat), 64'd4);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rcin = 1'($urandom); rsub = 1'($urandom);
      model(4, 64'(ra), 64'(rb), rcin, rsub, m_sum, m_cout, m_ovf);
      beat4(ra, rb, rcin, rsub, r_sum4, r_cout, r_ovf, lat);
      chk("rnd4_sum", 64'(r_sum4), m_sum);
      chk("rnd4_cout", 64'(r_cout), 64'(m_cout));
      chk("rnd4_ovf", 64'(r_ovf), 64'(m_ovf));
      chk("rnd4_latency", 64'(lat), 64'd4);
      @(posedge clk); #1;
    end

    // Back-to-back stream, no backpressure.
    accepts = 0; pops = 0; sb_en = 1'b1;
    send16(100, 1'b0);
    drain16();
    chk("stream_accepts", 64'(accepts), 64'd100);
    chk("stream_pops", 64'(pops), 64'd100);
    chk("stream_first_latency", 64'(first_pop - first_acc + 1), 64'd6);
    chk("stream_gapless", 64'(last_pop - first_pop), 64'd99);

    // Five-cycle output stall while beats keep arriving.
    accepts = 0; pops = 0;
    fork
      send16(12, 1'b1);
      begin
        guard = 0;
        while (!if16.out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("bp_valid_seen", 64'(if16.out_valid), 64'd1);
        if16.out_ready = 1'b0;
        held = if16.out_sum;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(if16.in_ready), 64'd0);
          chk("bp_out_valid", 64'(if16.out_valid), 64'd1);
          chk("bp_sum_stable", 64'(if16.out_sum), 64'(held));
          @(posedge clk); #1;
        end
        if16.out_ready = 1'b1;
      end
    join
    drain16();
    chk("bp_accepts", 64'(accepts), 64'd12);
    chk("bp_pops", 64'(pops), 64'd12);

    // Asynchronous reset with several beats in flight.
    accepts = 0; pops = 0;
    send16(8, 1'b0);
    chk("pre_rst_valid", 64'(if16.out_valid), 64'd1);
    sb_en = 1'b0;
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(if16.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(if16.out_sum), 64'd0);
    chk("mid_rst_cout", 64'(if16.out_cout), 64'd0);
    chk("mid_rst_ovf", 64'(if16.out_ovf), 64'd0);
    chk("mid_rst_in_ready", 64'(if16.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_ghost", 64'(if16.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    beat16(16'hFFFF, 16'h0000, 1'b1, 1'b0, r_sum16, r_cout, r_ovf, lat);
    chk("post_rst_sum", 64'(r_sum16), 64'h0000);
    chk("post_rst_cout", 64'(r_cout), 64'd1);
    chk("post_rst_ovf", 64'(r_ovf), 64'd0);
    chk("post_rst_latency", 64'(lat), 64'd6);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sklansky_pipe_adder.md
# sklansky_pipe_adder

Parametrised, fully pipelined Sklansky parallel-prefix adder/subtractor. It supersedes the fixed 4-bit combinational Sklansky adder with:
- generic power-of-two width;
- one register stage per prefix level;
- valid/ready flow control with backpressure;
- an add/subtract mode.

It sits in arithmetic datapaths that need one result per clock at high frequency.

## Interface
- WIDTH, 16, operand width; power of two, 4..64.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  0: A+B+cin; 1: A-B (computed as A+~B+1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  sum/difference, modulo 2^WIDTH.
- out_cout  output  1  carry-out; for subtract, 1 means no borrow (A>=B unsigned).
- out_ovf  output  1  two's-complement overflow; see Configuration.

## Operation
- Stage 0 (pre-process), registered:
  - b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
  - g[i] = a[i]&b'[i], p[i] = a[i]^b'[i].
  - c0 is carried as generate bit at position -1.
- Stages 1..LEVELS (prefix), each registered:
  - At level k, each bit i whose bit (k-1) is set combines with the last bit of the preceding 2^(k-1)-aligned group: G = Gi | Pi&Gj, P = Pi&Pj (Sklansky fan-out pattern).
  - p[] and the MSB operand bits travel alongside for the final stage.
- Stage LEVELS+1 (post-process), registered:
  - sum[i] = p[i] ^ Gcarry[i-1], with sum[0] = p[0]^c0.
  - cout = G[WIDTH-1:-1].
  - ovf = carry into MSB ^ cout.
- Each stage has a valid bit; data registers load only on accept/advance, never on idle cycles.
- Flow control is a global stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stalled, every stage register and valid bit holds.
  - Bubbles are not compressed.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- All arithmetic is unsigned modulo 2^WIDTH. out_ovf interprets operands as signed.

## Timing
- Latency is LEVELS+2 cycles from the accepting edge to out_valid=1, when not stalled. WIDTH=4 gives 4 cycles; WIDTH=16 gives 6.
- Throughput is one beat per cycle with out_ready held at 1.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset values: all stage valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
- If rst is asserted mid-operation, all in-flight beats are discarded immediately and asynchronously. No result emerges for them.
- in_valid=1 during a stall: the beat is not accepted. The source holds it.
- Back-to-back stall release: the beat on the input is accepted on the same edge the output beat is consumed.

## Configuration
- SKLANSKY_OVF_EN:
  - Defined: the post-process stage computes out_ovf as above. The MSB carry-in is piped through the stages.
  - Undefined: out_ovf is tied to 0, and the extra MSB tracking registers are not synthesised.
- Sum, cout and timing are identical in both builds.

## Test plan
- WIDTH=4, SKLANSKY_OVF_EN defined, single beats:
  - 1101+1011, cin=0 -> sum=1000, cout=1.
  - 1111+1111, cin=1 -> sum=1111, cout=1.
  - 0000+0000, cin=1 -> sum=0001, cout=0.
  - Each result appears exactly 4 cycles after acceptance.
- WIDTH=4, sub=1:
  - 0101-0111 -> sum=1110, cout=0.
  - 0111+0001 (add) -> sum=1000, ovf=1.
  - With SKLANSKY_OVF_EN undefined, the same add gives ovf=0.
- WIDTH=16 streaming: 100 random back-to-back beats with out_ready=1 -> 100 results in order, matching a+b+cin with no gaps, first result at cycle 6.
- Backpressure: hold out_ready=0 for 5 cycles while a result is valid -> in_ready=0 for the whole stall; out_sum is stable; no beat is lost or duplicated after release.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 immediately, all outputs 0; after release, the next accepted beat (FFFF+0000+1) -> sum=0000, cout=1, 6 cycles later.
